// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: a small FIFO feeds a serialiser whose frame format
// (baud divisor, data bits, parity, stop bits) is taken per frame, plus line break.
module uart_tx_buffered #(
  parameter int fifo_els_p      = 4,
  parameter int max_data_bits_p = 9,
  parameter int div_width_p     = 16,
  parameter int reset_div_p     = 10416
) (
  input  logic                               clk_i,
  input  logic                               reset_i,
  input  logic                               tx_v_i,
  input  logic [max_data_bits_p-1:0]         tx_i,
  output logic                               tx_ready_and_o,
  input  logic [div_width_p-1:0]             baud_div_i,
  input  logic [3:0]                         data_bits_i,
  input  logic [2:0]                         parity_mode_i,
  input  logic                               stop_bits_i,
  input  logic                               break_i,
  output logic                               tx_o,
  output logic                               busy_o,
  output logic                               tx_done_o,
  output logic [$clog2(fifo_els_p+1)-1:0]    count_o
);

  localparam int ptr_w_lp = (fifo_els_p > 1) ? $clog2(fifo_els_p) : 1;
  localparam int cnt_w_lp = $clog2(fifo_els_p + 1);
  localparam logic [cnt_w_lp-1:0]    full_cnt_lp = cnt_w_lp'(fifo_els_p);
  localparam logic [div_width_p-1:0] div_one_lp  = div_width_p'(1);
  localparam logic [div_width_p-1:0] div_min_lp  = div_width_p'(2);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;
  localparam logic [2:0] BREAK  = 3'd5;

  // The divisor always comes from baud_div_i; the reset divisor is kept only for compatibility.
  logic [31:0] unused_reset_div;
  assign unused_reset_div = 32'(reset_div_p);

  logic [max_data_bits_p-1:0] mem_r [fifo_els_p];
  logic [ptr_w_lp-1:0]        wr_ptr_r;
  logic [ptr_w_lp-1:0]        rd_ptr_r;
  logic [cnt_w_lp-1:0]        count_r;
  logic                       enq;
  logic                       deq;
  logic                       fifo_empty;

  assign tx_ready_and_o = (count_r != full_cnt_lp);
  assign fifo_empty     = (count_r == '0);
  assign enq            = tx_v_i & tx_ready_and_o;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (enq) wr_ptr_r <= wr_ptr_r + ptr_w_lp'(1);
      if (deq) rd_ptr_r <= rd_ptr_r + ptr_w_lp'(1);
      if (enq && !deq)      count_r <= count_r + cnt_w_lp'(1);
      else if (!enq && deq) count_r <= count_r - cnt_w_lp'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (enq) mem_r[wr_ptr_r] <= tx_i;
  end

  logic [div_width_p-1:0]     div_clamped;
  logic [3:0]                 nbits_clamped;
  logic [max_data_bits_p-1:0] data_mask;
  logic [max_data_bits_p-1:0] head_word;
  logic                       head_xor;
  logic                       par_en_next;
  logic                       par_val_next;

  // Clamped run-time format and parity of the word at the FIFO head, used when it is popped.
  always_comb begin
    div_clamped = (baud_div_i < div_min_lp) ? div_min_lp : baud_div_i;
    if (data_bits_i < 4'd5)      nbits_clamped = 4'd5;
    else if (data_bits_i > 4'd9) nbits_clamped = 4'd9;
    else                         nbits_clamped = data_bits_i;
    data_mask = '0;
    for (int i = 0; i < max_data_bits_p; i++) begin
      data_mask[i] = (i < int'(nbits_clamped));
    end
    head_word    = mem_r[rd_ptr_r] & data_mask;
    head_xor     = ^head_word;
    par_en_next  = 1'b0;
    par_val_next = 1'b0;
    case (parity_mode_i)
      3'd1: begin par_en_next = 1'b1; par_val_next = head_xor;  end
      3'd2: begin par_en_next = 1'b1; par_val_next = ~head_xor; end
      3'd3: begin par_en_next = 1'b1; par_val_next = 1'b1;      end
      3'd4: begin par_en_next = 1'b1; par_val_next = 1'b0;      end
      default: ;
    endcase
  end

  logic [2:0]                 state_r;
  logic [div_width_p-1:0]     clk_cnt_r;
  logic [3:0]                 bit_idx_r;
  logic [max_data_bits_p-1:0] shift_r;
  logic [div_width_p-1:0]     div_r;
  logic [3:0]                 nbits_r;
  logic                       par_en_r;
  logic                       par_bit_r;
  logic                       stop2_r;
  logic                       brk_mark_r;
  logic                       tx_r;
  logic                       done_r;
  logic                       line_val;
  logic                       bit_end;
  logic                       brk_end;
  logic                       last_stop;

  assign bit_end   = (clk_cnt_r >= div_r - div_one_lp);
  assign brk_end   = (clk_cnt_r >= div_clamped - div_one_lp);
  assign last_stop = (state_r == STOP) && bit_end && (!stop2_r || bit_idx_r[0]);
  assign deq       = !fifo_empty && !break_i && ((state_r == IDLE) || last_stop);

  always_comb begin
    line_val = 1'b1;
    case (state_r)
      START:   line_val = 1'b0;
      DATA:    line_val = shift_r[0];
      PARITY:  line_val = par_bit_r;
      BREAK:   line_val = brk_mark_r;
      default: line_val = 1'b1;
    endcase
  end

  // A pop (from IDLE or straight out of the last stop bit) latches the frame format;
  // the line register lags the state by one cycle so every bit lasts exactly div cycles.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r    <= IDLE;
      clk_cnt_r  <= '0;
      bit_idx_r  <= '0;
      shift_r    <= '0;
      div_r      <= div_min_lp;
      nbits_r    <= 4'd8;
      par_en_r   <= 1'b0;
      par_bit_r  <= 1'b0;
      stop2_r    <= 1'b0;
      brk_mark_r <= 1'b0;
      tx_r       <= 1'b1;
      done_r     <= 1'b0;
    end else begin
      tx_r   <= line_val;
      done_r <= last_stop;
      if (deq) begin
        state_r   <= START;
        clk_cnt_r <= '0;
        bit_idx_r <= '0;
        shift_r   <= head_word;
        div_r     <= div_clamped;
        nbits_r   <= nbits_clamped;
        par_en_r  <= par_en_next;
        par_bit_r <= par_val_next;
        stop2_r   <= stop_bits_i;
      end else begin
        case (state_r)
          IDLE: begin
            if (break_i) begin
              state_r    <= BREAK;
              brk_mark_r <= 1'b0;
              clk_cnt_r  <= '0;
            end
          end
          START: begin
            if (bit_end) begin
              state_r   <= DATA;
              clk_cnt_r <= '0;
              bit_idx_r <= '0;
            end else begin
              clk_cnt_r <= clk_cnt_r + div_one_lp;
            end
          end
          DATA: begin
            if (bit_end) begin
              clk_cnt_r <= '0;
              shift_r   <= shift_r >> 1;
              if (bit_idx_r == nbits_r - 4'd1) begin
                bit_idx_r <= '0;
                state_r   <= par_en_r ? PARITY : STOP;
              end else begin
                bit_idx_r <= bit_idx_r + 4'd1;
              end
            end else begin
              clk_cnt_r <= clk_cnt_r + div_one_lp;
            end
          end
          PARITY: begin
            if (bit_end) begin
              state_r   <= STOP;
              clk_cnt_r <= '0;
              bit_idx_r <= '0;
            end else begin
              clk_cnt_r <= clk_cnt_r + div_one_lp;
            end
          end
          STOP: begin
            if (bit_end) begin
              clk_cnt_r <= '0;
              if (last_stop) state_r   <= IDLE;
              else           bit_idx_r <= bit_idx_r + 4'd1;
            end else begin
              clk_cnt_r <= clk_cnt_r + div_one_lp;
            end
          end
          BREAK: begin
            // Hold the line low until break_i drops, then one mark bit at the live divisor.
            if (!brk_mark_r) begin
              if (!break_i) begin
                brk_mark_r <= 1'b1;
                clk_cnt_r  <= '0;
              end
            end else if (brk_end) begin
              state_r    <= IDLE;
              brk_mark_r <= 1'b0;
              clk_cnt_r  <= '0;
            end else begin
              clk_cnt_r <= clk_cnt_r + div_one_lp;
            end
          end
          default: state_r <= IDLE;
        endcase
      end
    end
  end

  assign tx_o      = tx_r;
  assign busy_o    = (state_r != IDLE);
  assign tx_done_o = done_r;
  assign count_o   = count_r;

endmodule
